// File: rtl/kf8259_interrupt_acknowledge_sequencer_if.sv
// Signal bundle between the KF8259 controller, the acknowledge sequencer and the CPU core.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface kf8259_interrupt_acknowledge_sequencer_if;
  logic       interrupt_to_cpu;
  logic       interrupt_enable;
  logic       cpu_ack_request;
  logic [7:0] pic_data_bus_out;
  logic       pic_data_bus_io;
  logic       interrupt_acknowledge_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_ready;
  logic       bus_error;
  logic       busy;

  modport slave (
    input  interrupt_to_cpu,
    input  interrupt_enable,
    input  cpu_ack_request,
    input  pic_data_bus_out,
    input  pic_data_bus_io,
    input  vector_ready,
    output interrupt_acknowledge_n,
    output vector,
    output vector_valid,
    output bus_error,
    output busy
  );

  modport master (
    output interrupt_to_cpu,
    output interrupt_enable,
    output cpu_ack_request,
    output pic_data_bus_out,
    output pic_data_bus_io,
    output vector_ready,
    input  interrupt_acknowledge_n,
    input  vector,
    input  vector_valid,
    input  bus_error,
    input  busy
  );
endinterface

// File: rtl/kf8259_interrupt_acknowledge_sequencer.sv
// Generates the two-pulse 8086-style INTA sequence, captures the controller's vector on the
// final edge of the second pulse and offers it to the core over a valid/ready handshake.
module kf8259_interrupt_acknowledge_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic                                     clock,
  input logic                                     reset_n,
  kf8259_interrupt_acknowledge_sequencer_if.slave ack_if
);

  localparam int unsigned CntW = $clog2(16) + 1;
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPulse1,
    StGap,
    StPulse2,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inta_n_q, inta_n_d;
  logic [7:0]      vector_q, vector_d;
  logic            valid_q, valid_d;
  logic            bus_error_q, bus_error_d;
  logic            busy_q, busy_d;
  logic            start;

  assign start = ack_if.interrupt_to_cpu & ack_if.interrupt_enable & ack_if.cpu_ack_request;

  // Once PULSE1 is entered the controller is committed, so later request changes are ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vector_d    = vector_q;
    bus_error_d = bus_error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPulse1;
          cnt_d   = PulseLoad;
        end
      end
      StPulse1: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StPulse2;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse2: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = '0;
          if (!ack_if.pic_data_bus_io) begin
            vector_d    = ack_if.pic_data_bus_out;
            bus_error_d = 1'b0;
          end else begin
            vector_d    = 8'hFF;
            bus_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (ack_if.vector_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    inta_n_d = !((state_d == StPulse1) || (state_d == StPulse2));
    valid_d  = (state_d == StHold);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      inta_n_q    <= 1'b1;
      vector_q    <= 8'h00;
      valid_q     <= 1'b0;
      bus_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inta_n_q    <= inta_n_d;
      vector_q    <= vector_d;
      valid_q     <= valid_d;
      bus_error_q <= bus_error_d;
      busy_q      <= busy_d;
    end
  end

  assign ack_if.interrupt_acknowledge_n = inta_n_q;
  assign ack_if.vector                  = vector_q;
  assign ack_if.vector_valid            = valid_q;
  assign ack_if.bus_error               = bus_error_q;
  assign ack_if.busy                    = busy_q;

endmodule

// File: tb/tb_kf8259_interrupt_acknowledge_sequencer.sv
// Bench for the INTA sequencer: cycle-by-cycle INTA/busy/valid checks plus a vector
// scoreboard, on a default-parameter instance and a PULSE_CYCLES=3 / GAP_CYCLES=1 instance.
module tb_kf8259_interrupt_acknowledge_sequencer;

  localparam int unsigned PA = 2;
  localparam int unsigned GA = 2;
  localparam int unsigned PB = 3;
  localparam int unsigned GB = 1;

  logic clock = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0] sb_q[$];
  logic valid_prev = 1'b0;

  kf8259_interrupt_acknowledge_sequencer_if ifa ();
  kf8259_interrupt_acknowledge_sequencer_if ifb ();

  kf8259_interrupt_acknowledge_sequencer #(
    .PULSE_CYCLES(PA),
    .GAP_CYCLES  (GA)
  ) u_dut_a (
    .clock  (clock),
    .reset_n(rst_a_n),
    .ack_if (ifa)
  );

  kf8259_interrupt_acknowledge_sequencer #(
    .PULSE_CYCLES(PB),
    .GAP_CYCLES  (GB)
  ) u_dut_b (
    .clock  (clock),
    .reset_n(rst_b_n),
    .ack_if (ifb)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_req_a(input logic v);
    ifa.interrupt_to_cpu = v;
    ifa.interrupt_enable = v;
    ifa.cpu_ack_request  = v;
  endtask

  // Scoreboard consumer: each rising vector_valid must match the oldest expected vector.
  always @(negedge clock) begin
    if (ifa.vector_valid === 1'b1 && valid_prev === 1'b0) begin
      check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check_eq("sb_vector", 32'(ifa.vector), 32'(e[7:0]));
        check_eq("sb_bus_error", 32'(ifa.bus_error), 32'(e[8]));
      end
    end
    valid_prev <= ifa.vector_valid;
  end

  // Called at a negedge in IDLE; returns at the negedge after the handshake (IDLE again).
  task automatic run_seq(input logic [7:0] data, input logic io, input logic keep_req,
                         input int stall);
    int         last;
    logic [7:0] vexp;
    logic       exp_inta;
    last = 2 * PA + GA + 1;
    vexp = io ? 8'hFF : data;
    set_req_a(1'b1);
    sb_q.push_back({io, vexp});
    @(negedge clock);
    for (int k = 1; k <= last; k++) begin
      if (k == 1 && !keep_req) set_req_a(1'b0);
      if (k == PA + GA + 1) begin
        ifa.pic_data_bus_out = data;
        ifa.pic_data_bus_io  = io;
      end
      exp_inta = ((k <= PA) || (k >= PA + GA + 1 && k <= 2 * PA + GA)) ? 1'b0 : 1'b1;
      check_eq($sformatf("inta_k%0d", k), 32'(ifa.interrupt_acknowledge_n), 32'(exp_inta));
      check_eq($sformatf("busy_k%0d", k), 32'(ifa.busy), 32'd1);
      check_eq($sformatf("valid_k%0d", k), 32'(ifa.vector_valid), 32'(k == last));
      if (k < last) @(negedge clock);
    end
    ifa.pic_data_bus_out = ~data;
    ifa.pic_data_bus_io  = ~io;
    for (int s = 0; s < stall; s++) begin
      ifa.vector_ready = 1'b0;
      @(negedge clock);
      check_eq("stall_valid", 32'(ifa.vector_valid), 32'd1);
      check_eq("stall_inta", 32'(ifa.interrupt_acknowledge_n), 32'd1);
      check_eq("stall_vector", 32'(ifa.vector), 32'(vexp));
      check_eq("stall_bus_error", 32'(ifa.bus_error), 32'(io));
    end
    ifa.vector_ready = 1'b1;
    @(negedge clock);
    ifa.vector_ready     = 1'b0;
    ifa.pic_data_bus_io  = 1'b1;
    ifa.pic_data_bus_out = 8'h00;
    check_eq("post_valid", 32'(ifa.vector_valid), 32'd0);
    check_eq("post_busy", 32'(ifa.busy), 32'd0);
    check_eq("post_inta", 32'(ifa.interrupt_acknowledge_n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_inta;
    // Reset with all inputs high.
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    set_req_a(1'b1);
    ifa.pic_data_bus_out = 8'hFF;
    ifa.pic_data_bus_io  = 1'b1;
    ifa.vector_ready     = 1'b1;
    ifb.interrupt_to_cpu = 1'b0;
    ifb.interrupt_enable = 1'b0;
    ifb.cpu_ack_request  = 1'b0;
    ifb.pic_data_bus_out = 8'h00;
    ifb.pic_data_bus_io  = 1'b1;
    ifb.vector_ready     = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_inta", 32'(ifa.interrupt_acknowledge_n), 32'd1);
    check_eq("rst_valid", 32'(ifa.vector_valid), 32'd0);
    check_eq("rst_vector", 32'(ifa.vector), 32'h00);
    check_eq("rst_busy", 32'(ifa.busy), 32'd0);
    check_eq("rst_bus_error", 32'(ifa.bus_error), 32'd0);
    set_req_a(1'b0);
    ifa.vector_ready = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clock);

    // Nominal sequence.
    run_seq(8'h0B, 1'b0, 1'b0, 0);

    // Masked request, with vector_ready high outside HOLD.
    ifa.interrupt_to_cpu = 1'b1;
    ifa.cpu_ack_request  = 1'b1;
    ifa.interrupt_enable = 1'b0;
    ifa.vector_ready     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq("mask_inta", 32'(ifa.interrupt_acknowledge_n), 32'd1);
      check_eq("mask_busy", 32'(ifa.busy), 32'd0);
      check_eq("mask_valid", 32'(ifa.vector_valid), 32'd0);
    end
    set_req_a(1'b0);
    ifa.vector_ready = 1'b0;
    @(negedge clock);

    // Bus error: controller not driving at the sample point.
    run_seq(8'h5A, 1'b1, 1'b0, 0);

    // Stall with request held, then back-to-back second sequence after one IDLE cycle.
    run_seq(8'hC3, 1'b0, 1'b1, 10);
    run_seq(8'h27, 1'b0, 1'b0, 0);

    // Instance B: drop INT during GAP, then reset during PULSE2.
    ifb.interrupt_to_cpu = 1'b1;
    ifb.interrupt_enable = 1'b1;
    ifb.cpu_ack_request  = 1'b1;
    ifb.pic_data_bus_out = 8'h33;
    ifb.pic_data_bus_io  = 1'b0;
    @(negedge clock);
    ifb.cpu_ack_request = 1'b0;
    for (int k = 1; k <= int'(PB + GB + 2); k++) begin
      if (k == PB + 1) ifb.interrupt_to_cpu = 1'b0;
      exp_inta = (k <= PB || k >= PB + GB + 1) ? 1'b0 : 1'b1;
      check_eq($sformatf("b_inta_k%0d", k), 32'(ifb.interrupt_acknowledge_n), 32'(exp_inta));
      check_eq($sformatf("b_busy_k%0d", k), 32'(ifb.busy), 32'd1);
      if (k < int'(PB + GB + 2)) @(negedge clock);
    end
    rst_b_n = 1'b0;
    @(negedge clock);
    check_eq("b_rst_inta", 32'(ifb.interrupt_acknowledge_n), 32'd1);
    check_eq("b_rst_busy", 32'(ifb.busy), 32'd0);
    check_eq("b_rst_valid", 32'(ifb.vector_valid), 32'd0);
    check_eq("b_rst_vector", 32'(ifb.vector), 32'h00);
    rst_b_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_eq("b_idle_inta", 32'(ifb.interrupt_acknowledge_n), 32'd1);
      check_eq("b_idle_busy", 32'(ifb.busy), 32'd0);
    end

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kf8259_interrupt_acknowledge_sequencer.md
# kf8259_interrupt_acknowledge_sequencer

- Sits between the KF8259 interrupt controller and the CPU core, immediately downstream of the controller.
- When the controller raises `interrupt_to_cpu`, interrupts are enabled and the core signals an instruction boundary, the block generates the two-pulse 8086-style INTA bus sequence on `interrupt_acknowledge_n`.
- It captures the vector the controller drives during the second pulse and hands that vector to the core over a valid/ready handshake.

## Interface

Parameters:
- PULSE_CYCLES, default 2: INTA low width per pulse, in clocks; legal range 1..16.
- GAP_CYCLES, default 2: INTA high time between the two pulses, in clocks; legal range 1..16.

Ports:
- clock  in  1  system clock; the block's only clock.
- reset_n  in  1  synchronous, active-low reset.
- interrupt_to_cpu  in  1  INT from the interrupt controller.
- interrupt_enable  in  1  CPU IF flag.
- cpu_ack_request  in  1  core is at an instruction boundary and can accept an interrupt.
- pic_data_bus_out  in  8  controller data output.
- pic_data_bus_io  in  1  controller bus direction; 0 = controller is driving.
- interrupt_acknowledge_n  out  1  INTA to the controller, active-low, registered.
- vector  out  8  captured interrupt vector.
- vector_valid  out  1  vector available to the core.
- vector_ready  in  1  core accepts the vector.
- bus_error  out  1  controller was not driving during capture; qualified by vector_valid.
- busy  out  1  sequence in progress (any state other than IDLE).

## Operation

State machine: IDLE, PULSE1, GAP, PULSE2, HOLD. All outputs are registered.

State behaviour:
- IDLE:
  - Advances to PULSE1 when interrupt_to_cpu, interrupt_enable and cpu_ack_request are all 1 in the same cycle.
  - Otherwise stays in IDLE.
  - cpu_ack_request is ignored in every other state.
- PULSE1: interrupt_acknowledge_n=0 for PULSE_CYCLES clocks, then GAP.
- GAP: interrupt_acknowledge_n=1 for GAP_CYCLES clocks, then PULSE2.
- PULSE2:
  - interrupt_acknowledge_n=0 for PULSE_CYCLES clocks.
  - On the last PULSE2 clock edge:
    - If pic_data_bus_io=0: vector <= pic_data_bus_out and bus_error <= 0.
    - Otherwise: vector <= 8'hFF and bus_error <= 1.
  - Then HOLD.
- HOLD:
  - interrupt_acknowledge_n=1 and vector_valid=1.
  - vector and bus_error are held stable.
  - Returns to IDLE on the cycle vector_ready=1.
  - vector_valid drops on the same edge.

Shared phase counter:
- One down-counter of width clog2(16)+1 serves all timed phases.
- It is loaded with (length−1) on phase entry.
- The phase ends when the counter reads 0.

Boundary behaviour:
- interrupt_to_cpu or interrupt_enable deasserting after IDLE is left: the sequence runs to completion, because the controller has already committed the first acknowledge.
- vector_ready high outside HOLD: ignored.
- vector_ready held high continuously: HOLD lasts exactly 1 cycle.
- Back-to-back interrupts: at least one IDLE cycle separates HOLD from the next PULSE1.
- Reset mid-sequence: the FSM returns to IDLE and interrupt_acknowledge_n returns high at the next edge. A half-completed acknowledge is never resumed.

Reset values:
- interrupt_acknowledge_n=1.
- vector=8'h00, vector_valid=0, bus_error=0, busy=0.
- State=IDLE, counter=0.

## Timing

- Define cycle 0 as the edge at which the start condition is sampled. P = PULSE_CYCLES, G = GAP_CYCLES.
- interrupt_acknowledge_n:
  - low during cycles 1..P;
  - high during cycles P+1..P+G;
  - low during cycles P+G+1..2P+G.
- vector_valid=1 from cycle 2P+G+1.
- With default parameters: INTA low in cycles 1–2 and 5–6, vector_valid rises in cycle 7.
- busy:
  - goes high in cycle 1;
  - stays high through HOLD;
  - goes low on the cycle after the vector_ready handshake.
- The vector sample point is the final PULSE2 edge. The controller must present data at least one clock before that edge; PULSE_CYCLES≥2 guarantees this.
- No combinational paths from any input to any output.

## Test plan

- **Reset:** hold reset_n=0 for 3 cycles with all inputs at 1 → interrupt_acknowledge_n=1, vector_valid=0, vector=8'h00, busy=0.
- **Nominal sequence:** defaults; pulse INT+IF+ack for one cycle, controller drives 8'h0B with io=0 during PULSE2 → INTA low in cycles 1–2 and 5–6, vector=8'h0B, bus_error=0, vector_valid rises in cycle 7.
- **Masked request:** interrupt_enable=0 with INT and ack high for 20 cycles → interrupt_acknowledge_n stays 1, busy stays 0.
- **Bus error:** pic_data_bus_io=1 during PULSE2 → vector=8'hFF, bus_error=1, vector_valid=1.
- **Stall then back-to-back:** hold vector_ready=0 for 10 cycles, with INT still asserted → vector stable, no new INTA pulses; after ready, exactly one IDLE cycle, then the next PULSE1.
- **Mid-sequence events and reset:**
  - With P=3, G=1: drop INT during GAP → the second pulse still occurs.
  - Assert reset_n=0 during PULSE2 → interrupt_acknowledge_n=1 and busy=0 at the next edge.
